// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by the instruction encoder and the control unit's decoder,
// so the two sides of the instruction word layout cannot drift apart.
package cpu_isa_pkg;

   typedef enum logic [4:0] {
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SLT, OP_JR,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_BGT, OP_BGTE, OP_BLE, OP_BLEQ,
      OP_J, OP_JAL
   } op_e;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_SLTIU = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_BEQ   = 6'h18;
   localparam logic [5:0] OPC_BNE   = 6'h19;
   localparam logic [5:0] OPC_BGT   = 6'h1A;
   localparam logic [5:0] OPC_BGTE  = 6'h1B;
   localparam logic [5:0] OPC_BLE   = 6'h1C;
   // 1Dh is reserved by the decoder; bleq skips it.
   localparam logic [5:0] OPC_BLEQ  = 6'h1E;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   // Field layout: opc[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
      return {OPC_RTYPE, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] tgt);
      return {opc, tgt};
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op plus fields to a 32-bit instruction word,
// flagging op codes outside the legal range.
module instr_pack
   import cpu_isa_pkg::*;
(
   input  logic [4:0]  op_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  shamt_i,
   input  logic [25:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   logic [15:0] imm16;
   assign imm16 = imm_i[15:0];

   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (op_i)
         OP_ADD:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_ADD);
         OP_ADDU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_ADDU);
         OP_SUB:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_SUB);
         OP_SUBU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_SUBU);
         OP_AND:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_AND);
         OP_OR:    word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_OR);
         OP_SLL:   word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FUNCT_SLL);
         OP_SRL:   word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FUNCT_SRL);
         OP_SLT:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FUNCT_SLT);
         OP_JR:    word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FUNCT_JR);
         OP_ADDI:  word_o = i_word(OPC_ADDI, rs_i, rt_i, imm16);
         OP_ADDIU: word_o = i_word(OPC_ADDIU, rs_i, rt_i, imm16);
         OP_SLTI:  word_o = i_word(OPC_SLTI, rs_i, rt_i, imm16);
         OP_SLTIU: word_o = i_word(OPC_SLTIU, rs_i, rt_i, imm16);
         OP_ANDI:  word_o = i_word(OPC_ANDI, rs_i, rt_i, imm16);
         OP_ORI:   word_o = i_word(OPC_ORI, rs_i, rt_i, imm16);
         OP_LW:    word_o = i_word(OPC_LW, rs_i, rt_i, imm16);
         OP_SW:    word_o = i_word(OPC_SW, rs_i, rt_i, imm16);
         OP_BEQ:   word_o = i_word(OPC_BEQ, rs_i, rt_i, imm16);
         OP_BNE:   word_o = i_word(OPC_BNE, rs_i, rt_i, imm16);
         OP_BGT:   word_o = i_word(OPC_BGT, rs_i, rt_i, imm16);
         OP_BGTE:  word_o = i_word(OPC_BGTE, rs_i, rt_i, imm16);
         OP_BLE:   word_o = i_word(OPC_BLE, rs_i, rt_i, imm16);
         OP_BLEQ:  word_o = i_word(OPC_BLEQ, rs_i, rt_i, imm16);
         OP_J:     word_o = j_word(OPC_J, imm_i);
         OP_JAL:   word_o = j_word(OPC_JAL, imm_i);
         default:  illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Session-based loader: accepts symbolic instructions, encodes them and writes
// them to consecutive IMEM word addresses starting at base_addr.
module instr_encode_loader
   import cpu_isa_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              end_load,
   // in_valid/in_ready: a transfer occurs on every rising edge where both are 1;
   // in_ready never depends on in_valid, and the fields are sampled on the transfer edge.
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [25:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic              err_illegal,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_DONE, S_FULL} state_e;

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              end_pend_q, end_pend_d;
   logic              err_q, err_d;

   logic [31:0] packed_word;
   logic        packed_illegal;
   logic        transfer;

   instr_pack u_pack (
      .op_i      (in_op),
      .rs_i      (in_rs),
      .rt_i      (in_rt),
      .rd_i      (in_rd),
      .shamt_i   (in_shamt),
      .imm_i     (in_imm),
      .word_o    (packed_word),
      .illegal_o (packed_illegal)
   );

   assign transfer = in_valid && (state_q == S_LOAD);

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      wdata_d    = wdata_q;
      end_pend_d = end_pend_q;
      err_d      = err_q;
      // start reopens a session from any state, dropping any word still in flight.
      if (start) begin
         state_d    = S_LOAD;
         base_d     = base_addr;
         count_d    = '0;
         end_pend_d = 1'b0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (transfer && !packed_illegal) begin
                  state_d    = S_WR;
                  wdata_d    = packed_word;
                  end_pend_d = end_load;
               end else begin
                  if (transfer) err_d = 1'b1;
                  if (end_load) state_d = S_DONE;
               end
            end
            S_WR: begin
               count_d = count_q + 1'b1;
               if (count_d == DEPTH_C)            state_d = S_FULL;
               else if (end_pend_q || end_load)   state_d = S_DONE;
               else                               state_d = S_LOAD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         wdata_q    <= '0;
         end_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         wdata_q    <= wdata_d;
         end_pend_q <= end_pend_d;
         err_q      <= err_d;
      end
   end

   assign in_ready    = (state_q == S_LOAD);
   assign busy        = (state_q == S_LOAD) || (state_q == S_WR);
   assign done        = (state_q == S_DONE);
   assign full        = (state_q == S_FULL);
   assign imem_we     = (state_q == S_WR) && !start;
   assign imem_addr   = base_q + count_q[ADDR_W-1:0];
   assign imem_wdata  = wdata_q;
   assign word_count  = count_q;
   assign err_illegal = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed ISA examples plus random
// sessions, all compared against a session-level behavioural model every cycle.
module tb_instr_encode_loader;
  import cpu_isa_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start, end_load, in_valid;
  logic [ADDR_W-1:0] base_addr;
  logic [4:0] in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  logic in_ready, imem_we, busy, done, full, err_illegal;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [ADDR_W:0] word_count;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .end_load(end_load), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .busy(busy), .done(done), .full(full), .err_illegal(err_illegal),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];   // encoded word waiting to be written
  bit  m_open, m_done, m_full, m_err, m_end_req;
  int  m_cnt, m_base;

  bit          lit_en;
  logic [31:0] lit_data;
  logic [7:0]  lit_addr;

  int r_funct[10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h00, 'h02, 'h2A, 'h08};
  int i_opc[16]   = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h23, 'h2B,
                      'h18, 'h19, 'h1A, 'h1B, 'h1C, 'h1E, 'h02, 'h03};

  // Returns {illegal, word}
  function automatic logic [32:0] enc(int op, int rs, int rt, int rd, int sh, int imm);
    longint w;
    if (op <= 9) begin
      if (op != 6 && op != 7) sh = 0;
      if (op == 9) begin rt = 0; rd = 0; end
      w = (rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + r_funct[op];
    end else if (op <= 23) begin
      w = (longint'(i_opc[op-10]) << 26) + (rs << 21) + (rt << 16) + (imm % 65536);
    end else if (op <= 25) begin
      w = (longint'(i_opc[op-10]) << 26) + (imm % 67108864);
    end else begin
      return {1'b1, 32'h0};
    end
    return {1'b0, w[31:0]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_open = 0; m_done = 0; m_full = 0; m_err = 0; m_end_req = 0;
    m_cnt = 0; m_base = 0;
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = m_open && (exp_q.size() != 0) && !start;
    chk("imem_we", imem_we, exp_we);
    if (exp_we) begin
      chk("imem_addr", imem_addr, (m_base + m_cnt) % 256);
      chk("imem_wdata", imem_wdata, exp_q[0]);
    end
    chk("in_ready", in_ready, m_open && exp_q.size() == 0);
    chk("busy", busy, m_open);
    chk("done", done, m_done);
    chk("full", full, m_full);
    chk("err_illegal", err_illegal, m_err);
    chk("word_count", word_count, m_cnt);
    if (lit_en) begin
      chk("lit_we", imem_we, 1);
      chk("lit_wdata", imem_wdata, lit_data);
      chk("lit_addr", imem_addr, lit_addr);
      lit_en = 0;
    end
  endtask

  task automatic update_model();
    logic [32:0] e;
    if (!rst_n) begin
      model_reset();
    end else if (start) begin
      exp_q.delete();
      m_open = 1; m_done = 0; m_full = 0; m_err = 0; m_end_req = 0;
      m_cnt = 0; m_base = int'(base_addr);
    end else if (m_open && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      m_cnt++;
      if (m_cnt == DEPTH) begin m_open = 0; m_full = 1; end
      else if (m_end_req || end_load) begin m_open = 0; m_done = 1; end
    end else if (m_open) begin
      e = enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt), int'(in_imm));
      if (in_valid && !e[32]) begin
        exp_q.push_back(e[31:0]);
        m_end_req = end_load;
      end else begin
        if (in_valid) m_err = 1;
        if (end_load) begin m_open = 0; m_done = 1; end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    #1;
    check_outputs();
    update_model();
    @(negedge clk);
  endtask

  task automatic do_start(logic [7:0] b);
    start = 1; base_addr = b;
    step();
    start = 0;
  endtask

  task automatic send(op_e op, int rs, int rt, int rd, int sh, int imm,
                      bit el, bit el_wr, bit lit, logic [31:0] ld, logic [7:0] la);
    in_op = op; in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 26'(imm);
    in_valid = 1; end_load = el;
    step();
    in_valid = 0; end_load = el_wr;
    lit_en = lit; lit_data = ld; lit_addr = la;
    step();
    end_load = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; start = 0; end_load = 0; in_valid = 0; base_addr = '0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
    lit_en = 0; lit_data = '0; lit_addr = '0;
    model_reset();
    @(negedge clk);
    step();
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    rst_n = 1;
    step();

    // add rs=1 rt=2 rd=3 at 10h
    do_start(8'h10);
    send(OP_ADD, 1, 2, 3, 0, 0, 0, 0, 1, 32'h00221820, 8'h10);
    chk("t1_count", word_count, 1);

    // addi / ori, then a word with end_load raised during its write cycle
    do_start(8'h10);
    send(OP_ADDI, 0, 8, 0, 0, 'hFFFF, 0, 0, 1, 32'h2008FFFF, 8'h10);
    send(OP_ORI, 0, 9, 0, 0, 'h00FF, 0, 0, 1, 32'h340900FF, 8'h11);
    send(OP_SUB, 4, 5, 6, 7, 0, 0, 1, 1, 32'h00853022, 8'h12);
    chk("t2_done", done, 1);

    // beq (opcode 18h), jal, sll; last one closes with end_load on the transfer
    do_start(8'h10);
    send(OP_BEQ, 1, 2, 0, 0, 'h0004, 0, 0, 1, 32'h60220004, 8'h10);
    send(OP_JAL, 0, 0, 0, 0, 'h40, 0, 0, 1, 32'h0C000040, 8'h11);
    send(OP_SLL, 0, 2, 4, 3, 0, 1, 0, 1, 32'h000220C0, 8'h12);
    chk("t3_done", done, 1);
    chk("t3_count", word_count, 3);

    // illegal op then jr at the unchanged address
    do_start(8'h10);
    in_op = 5'd27; in_valid = 1;
    step();
    in_valid = 0;
    chk("t4_err", err_illegal, 1);
    chk("t4_count", word_count, 0);
    send(OP_JR, 7, 3, 3, 3, 0, 0, 0, 1, 32'h00E00008, 8'h10);

    // fill to DEPTH
    do_start(8'h20);
    for (int i = 0; i < DEPTH; i++)
      send(OP_LW, i, i + 1, 0, 0, 'h100 + i, 0, 0, 0, 0, 0);
    chk("t5_full", full, 1);
    chk("t5_ready", in_ready, 0);
    in_valid = 1; end_load = 1;
    repeat (3) step();
    in_valid = 0; end_load = 0;
    do_start(8'h40);
    chk("t5_full_clr", full, 0);

    // abort in flight with start, then async reset mid-write
    do_start(8'h30);
    in_op = OP_AND; in_rs = 1; in_rt = 1; in_rd = 1; in_valid = 1;
    step();
    in_valid = 0; start = 1; base_addr = 8'h80;
    #1 chk("t6_abort_we", imem_we, 0);
    step();
    start = 0;
    send(OP_OR, 1, 2, 3, 0, 0, 0, 0, 1, 32'h00221825, 8'h80);
    chk("t6_count", word_count, 1);
    in_op = OP_BNE; in_valid = 1;
    step();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_rst_we", imem_we, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", word_count, 0);
    chk("t6_rst_addr", imem_addr, 0);
    chk("t6_rst_wdata", imem_wdata, 0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1;
    step();

    // randomized sessions
    for (int c = 0; c < 1500; c++) begin
      start     = ($urandom_range(0, 29) == 0);
      base_addr = 8'($urandom_range(0, 255));
      end_load  = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 5'($urandom_range(0, 31));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_shamt  = 5'($urandom);
      in_imm    = 26'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
